// File: rtl/stream_unpack_if.sv
// stream_unpack_if: bundles the serialized-chain input stream and the
// frame readout/status signals of stream_unpack.
//   master : stream/readout driver (host side / testbench)
//   slave  : stream_unpack
// Parameters: dwi = sample width, aw = read-address width.
interface stream_unpack_if #(
  parameter int dwi = 28,
  parameter int aw  = 3
);
  logic                  strobe;
  logic signed [dwi-1:0] stream_in;
  logic                  gate_in;
  logic [aw-1:0]         rd_addr;
  logic signed [dwi-1:0] rd_data;
  logic                  frame_valid;
  logic                  frame_ack;
  logic [7:0]            frame_seq;
  logic                  len_err;
  logic [15:0]           overrun_cnt;

  modport master (
    output strobe, stream_in, gate_in, rd_addr, frame_ack,
    input  rd_data, frame_valid, frame_seq, len_err, overrun_cnt
  );

  modport slave (
    input  strobe, stream_in, gate_in, rd_addr, frame_ack,
    output rd_data, frame_valid, frame_seq, len_err, overrun_cnt
  );
endinterface

// File: rtl/stream_unpack.sv
// stream_unpack: captures the burst at the tail of a serialize chain into
// a ping-pong pair of register banks and exposes the last published frame
// for random-access readout.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : strobe/stream_in/gate_in burst input, rd_addr/rd_data
//                     readout (1-cycle latency), frame_valid/frame_ack
//                     handshake, frame_seq, len_err pulse, overrun_cnt
// Parameters: dwi sample width, nch channels per frame, aw read-address width.
// Build option: define STREAM_UNPACK_OVERRUN_CNT_EN to build the 16-bit
// saturating dropped-frame counter; otherwise overrun_cnt is tied to 0.
module stream_unpack #(
  parameter int dwi = 28,
  parameter int nch = 8,
  parameter int aw  = 3
) (
  input logic            clk,
  input logic            rst_n,
  stream_unpack_if.slave bus
);
  localparam int cw = $clog2(nch + 1);
  localparam int iw = (nch > 1) ? $clog2(nch) : 1;
  localparam logic [cw-1:0] last = cw'(nch);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                       state, state_nxt;
  logic [cw-1:0]                cnt, cnt_nxt;
  logic                         wbank;      // bank currently filling; ~wbank is held
  logic                         has_frame;  // a frame has been published since reset
  logic                         wr_en, err, done, publish;
  logic                         in_range;
  logic [1:0][nch-1:0][dwi-1:0] bank;

  // Burst framing. A strobe always restarts the burst; the word riding on
  // the strobe cycle belongs to the abandoned burst and is dropped.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    err       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.strobe) begin
          state_nxt = COLLECT;
          cnt_nxt   = '0;
        end
      end
      COLLECT: begin
        if (bus.strobe) begin
          err     = (cnt != '0);
          cnt_nxt = '0;
        end else if (bus.gate_in) begin
          if (cnt < last) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + 1'b1;
          end else begin
            err       = 1'b1;
            state_nxt = IDLE;
          end
        end else if (cnt != '0) begin
          // gate dropped: burst over, length decides the outcome
          if (cnt == last) done = 1'b1;
          else             err  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // An ack in the completion cycle frees the held bank just in time.
  assign publish  = done && (!bus.frame_valid || bus.frame_ack);
  assign in_range = 32'(bus.rd_addr) < nch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      wbank           <= 1'b0;
      has_frame       <= 1'b0;
      bus.frame_valid <= 1'b0;
      bus.frame_seq   <= '0;
      bus.len_err     <= 1'b0;
      bus.rd_data     <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bus.len_err <= err;
      if (publish) begin
        wbank           <= ~wbank;
        has_frame       <= 1'b1;
        bus.frame_valid <= 1'b1;
        bus.frame_seq   <= bus.frame_seq + 8'd1;
      end else if (bus.frame_ack) begin
        bus.frame_valid <= 1'b0;
      end
      // Bank contents are never cleared, so mask reads until a frame exists.
      bus.rd_data <= (has_frame && in_range) ? bank[~wbank][bus.rd_addr[iw-1:0]] : '0;
    end
  end

  // Sample storage: only the filling bank is ever written.
  always_ff @(posedge clk) begin
    if (wr_en) bank[wbank][cnt[iw-1:0]] <= bus.stream_in;
  end

`ifdef STREAM_UNPACK_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bus.overrun_cnt <= '0;
    else if (done && !publish && bus.overrun_cnt != 16'hFFFF)
      bus.overrun_cnt <= bus.overrun_cnt + 16'd1;
  end
`else
  assign bus.overrun_cnt = '0;
`endif

endmodule

// File: doc/stream_unpack.md
# stream_unpack

Collects the serialized channel burst emitted at the tail of a `serialize` chain and turns it into a random-access frame of `nch` samples for a host or DSP consumer. Capture goes through a ping-pong pair of register banks: one bank fills from the stream while the other is held for readout. Length errors and frames dropped because the reader has not released its bank are detected and reported.

## Interface
- `dwi`, 28, sample width; matches the chain's `dwi`.
- `nch`, 8, channels per frame, 2..256; equals the number of chain stages.
- `aw`, 3, read-address width; 2^`aw` >= `nch`.
- `clk`  input  1  timespec 8.4 ns; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `strobe`  input  1  chain `strobe_out` (samp); marks the start of a burst.
- `stream_in`  input  `dwi` signed  chain `stream_out`.
- `gate_in`  input  1  chain `gate_out`; high while `stream_in` carries a valid sample.
- `rd_addr`  input  `aw`  channel index to read from the published bank.
- `rd_data`  output  `dwi` signed  registered read data.
- `frame_valid`  output  1  a published frame is held for readout.
- `frame_ack`  input  1  one-cycle pulse that releases the published bank.
- `frame_seq`  output  8  count of published frames, modulo 256.
- `len_err`  output  1  one-cycle pulse when a burst with wrong length is discarded.
- `overrun_cnt`  output  16  count of dropped complete frames, saturating.

## Operation
- Reset values: all outputs are 0; `state`=IDLE; `wbank`=0; `cnt`=0.
- State IDLE:
  - `strobe`=1 -> COLLECT, `cnt`<=0.
  - `gate_in` outside COLLECT is ignored.
- State COLLECT, `gate_in`=1:
  - If `cnt`<`nch`: write `bank[wbank][cnt]`<=`stream_in`, then `cnt`++.
  - If `cnt`==`nch`: this is an extra word. Pulse `len_err` and go to IDLE.
- State COLLECT, `gate_in`=0 after at least one word: the burst has ended.
  - If `cnt`==`nch`, the frame completes (see Publish).
  - Otherwise pulse `len_err` and go to IDLE.
- State COLLECT, `gate_in`=0 before any word: keep waiting.
- `strobe`=1 while in COLLECT:
  - If words have already been written, pulse `len_err` and restart the burst (`cnt`<=0, stay in COLLECT).
  - If no words have been written yet, just restart.
- Publish (frame complete):
  - If `frame_valid`=0, or `frame_ack`=1 in the same cycle: swap `wbank`, set `frame_valid`=1, `frame_seq`++.
  - Otherwise drop the frame, `overrun_cnt`++ (saturating at 0xFFFF), and keep `wbank`.
  - In either case go to IDLE.
- Release: `frame_ack`=1 with no simultaneous publish clears `frame_valid`. `frame_ack` while `frame_valid`=0 has no effect.
- Readout:
  - `rd_data` <= `bank[~wbank][rd_addr]` every cycle, regardless of `frame_valid`.
  - An address >= `nch` returns 0.
- The held bank is never written while `frame_valid`=1.
- Reset mid-burst discards the partial frame. Bank contents need not be cleared, but `rd_data` reads 0 until the first publish.

## Timing
- Chain timing: with `strobe` at cycle T, `gate_in` is high for T+1..T+`nch`, and channel k (nearest stage first) appears at T+1+k.
- Completion is detected at T+`nch`+1. `frame_valid` rises at T+`nch`+2, and `frame_seq` updates in the same cycle.
- Read latency: `rd_data` is valid one cycle after `rd_addr` is presented.
- `frame_ack` at cycle A: `frame_valid` is 0 at A+1, unless a publish occurs at A.
- `len_err` is high at the cycle after the detecting edge.
- Back-to-back strobes with spacing >= `nch`+2 cycles never overrun, provided every frame is acked within the strobe interval.

## Configuration
- `STREAM_UNPACK_OVERRUN_CNT_EN`
  - Defined: the 16-bit saturating overrun counter is built as described.
  - Undefined: `overrun_cnt` is tied to 0 and no counter logic is generated. Drop behaviour is unchanged.

## Test plan
- Normal frame, `nch`=8, samples 0x100+k, `strobe` at T -> `frame_valid`=1 at T+10. Reading `rd_addr` 0..7 returns 0x100..0x107 one cycle later. `frame_seq`=1.
- Short burst (gate high for 6 cycles) -> `len_err` pulse, `frame_valid` stays 0, `frame_seq` unchanged.
- Second complete frame arrives before `frame_ack` -> `frame_valid` stays 1, first frame's data unchanged, `overrun_cnt`=1 (0 with the macro undefined).
- `frame_ack` in the exact completion cycle of the next frame -> `frame_valid` stays 1, reads return the new frame, `frame_seq`=2, no overrun.
- `strobe` re-asserted at T+4 mid-burst -> `len_err` pulse. The restarted burst then completes normally with the new data.
- `rst_n` low at T+3 of a burst, released at T+5 -> all outputs 0. The next full strobe/burst publishes correctly with `frame_seq`=1.
